// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and the framer state type.
// Column constants are 64-bit lane vectors; lane 0 sits in bits [7:0].
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_ERROR    = 8'hFE;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;

    localparam logic [63:0] IDLE_COLUMN     = {8{XGMII_IDLE}};
    localparam logic [63:0] PREAMBLE_COLUMN = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
    localparam logic [63:0] TERM_COLUMN     = {{7{XGMII_IDLE}}, XGMII_TERM};
    localparam logic [63:0] ERROR_COLUMN    = {8{XGMII_ERROR}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TERM,
        ST_IFG
    } tx_state_t;

endpackage

// File: rtl/xgmii_term_lane.sv
// Builds the column that closes a partial last word: data lanes, then the
// terminate character, then idles. mod = 0 yields the plain terminate column.
module xgmii_term_lane
    import xgmii_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  mod,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    always_comb begin
        txd = data;
        txc = 8'hFF << mod;
        for (int n = 0; n < 8; n++) begin
            if (n == int'(mod)) begin
                txd[8*n +: 8] = XGMII_TERM;
            end else if (n > int'(mod)) begin
                txd[8*n +: 8] = XGMII_IDLE;
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_framer.sv
// Frames a 64-bit packet stream onto XGMII: start/preamble column, payload,
// terminate (or error on underrun), then a minimum inter-frame gap.
module xgmii_tx_framer
    import xgmii_pkg::*;
#(
    parameter int unsigned IFG_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pkt_data,
    input  logic        pkt_valid,
    input  logic        pkt_sop,
    input  logic        pkt_eop,
    input  logic [2:0]  pkt_mod,
    output logic        pkt_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        underrun_err,
    output logic [31:0] tx_frame_cnt
);

    // Handshake: a word moves when pkt_valid && pkt_ready at a rising clk edge;
    // pkt_ready never depends on the word being accepted and is low in reset.
    localparam logic [3:0] IFG_LAST = 4'(IFG_WORDS - 1);

    tx_state_t   state, state_nxt;
    logic [3:0]  ifg_cnt, ifg_cnt_nxt;
    logic [63:0] txd_nxt, term_txd;
    logic [7:0]  txc_nxt, term_txc;
    logic        underrun_nxt;
    logic        term_now;
    logic [31:0] frame_cnt, frame_cnt_nxt;

    xgmii_term_lane u_term_lane (
        .data (pkt_data),
        .mod  (pkt_mod),
        .txd  (term_txd),
        .txc  (term_txc)
    );

    always_comb begin
        state_nxt    = state;
        ifg_cnt_nxt  = ifg_cnt;
        txd_nxt      = IDLE_COLUMN;
        txc_nxt      = 8'hFF;
        underrun_nxt = 1'b0;
        term_now     = 1'b0;
        pkt_ready    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A start word waits here unconsumed; stray mid-frame words are dropped.
                if (pkt_valid) begin
                    if (pkt_sop) state_nxt = ST_PREAMBLE;
                    else         pkt_ready = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                txd_nxt   = PREAMBLE_COLUMN;
                txc_nxt   = 8'h01;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                pkt_ready = 1'b1;
                if (!pkt_valid) begin
                    txd_nxt      = ERROR_COLUMN;
                    underrun_nxt = 1'b1;
                    ifg_cnt_nxt  = 4'd0;
                    state_nxt    = ST_IFG;
                end else if (pkt_eop && (pkt_mod != 3'd0)) begin
                    txd_nxt     = term_txd;
                    txc_nxt     = term_txc;
                    term_now    = 1'b1;
                    ifg_cnt_nxt = 4'd0;
                    state_nxt   = ST_IFG;
                end else begin
                    txd_nxt = pkt_data;
                    txc_nxt = 8'h00;
                    if (pkt_eop) state_nxt = ST_TERM;
                end
            end
            ST_TERM: begin
                txd_nxt     = TERM_COLUMN;
                term_now    = 1'b1;
                ifg_cnt_nxt = 4'd0;
                state_nxt   = ST_IFG;
            end
            ST_IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    ifg_cnt_nxt = 4'd0;
                    state_nxt   = ST_IDLE;
                end else begin
                    ifg_cnt_nxt = ifg_cnt + 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) pkt_ready = 1'b0;
    end

    assign frame_cnt_nxt = frame_cnt + {31'd0, term_now};
    assign tx_frame_cnt  = frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ifg_cnt      <= 4'd0;
            xgmii_txd    <= IDLE_COLUMN;
            xgmii_txc    <= 8'hFF;
            underrun_err <= 1'b0;
            frame_cnt    <= 32'd0;
        end else begin
            state        <= state_nxt;
            ifg_cnt      <= ifg_cnt_nxt;
            xgmii_txd    <= txd_nxt;
            xgmii_txc    <= txc_nxt;
            underrun_err <= underrun_nxt;
            frame_cnt    <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: drivers push expected columns into a
// queue, a negedge monitor pops and compares every non-idle column.
module tb_xgmii_tx_framer;

    localparam logic [71:0] IDLE_COL = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] PRE_COL  = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] TERM_COL = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] ERR_COL  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
    localparam int MIN_GAP = 3;

    logic        clk;
    logic        rst;
    logic [63:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [2:0]  pkt_mod;
    logic        pkt_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        underrun_err;
    logic [31:0] tx_frame_cnt;

    logic [71:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_start_cyc = -1;
    int rel_cyc;
    int gap = 0;
    bit after_end = 0;

    xgmii_tx_framer #(.IFG_WORDS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_mod      (pkt_mod),
        .pkt_ready    (pkt_ready),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .underrun_err (underrun_err),
        .tx_frame_cnt (tx_frame_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [71:0] col;
        logic [71:0] e;
        bit is_end;
        cyc++;
        if (rst) begin
            after_end = 0;
            gap = 0;
        end else begin
            col = {xgmii_txc, xgmii_txd};
            if (col == IDLE_COL) begin
                if (after_end) gap++;
                if (underrun_err) check("underrun_on_idle", 72'(underrun_err), 72'(0));
            end else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_column", col, IDLE_COL);
                end else begin
                    e = exp_q.pop_front();
                    check("column", col, e);
                    check("underrun_flag", 72'(underrun_err), 72'(e == ERR_COL));
                end
                is_end = (col == ERR_COL);
                for (int n = 0; n < 8; n++)
                    if (xgmii_txc[n] && xgmii_txd[8*n +: 8] == 8'hFD) is_end = 1;
                if (xgmii_txc[0] && xgmii_txd[7:0] == 8'hFB) begin
                    last_start_cyc = cyc;
                    if (after_end) check("ifg_gap_ok", 72'(gap >= MIN_GAP), 72'(1));
                    after_end = 0;
                end else if (is_end) begin
                    after_end = 1;
                    gap = 0;
                end
            end
        end
    end

    // driver tasks
    task automatic wait_ready(output bit ok);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pkt_ready && k < 50);
        ok = pkt_ready;
        if (!ok) check("ready_timeout", 72'(0), 72'(1));
    endtask

    task automatic send_frame(input int n, input logic [63:0] base, input logic [2:0] mod,
                              input logic [71:0] last_col, input bit mid_sop, input bit underrun);
        logic [63:0] w;
        bit ok;
        exp_q.push_back(PRE_COL);
        for (int i = 0; i < n; i++) begin
            w = base + 64'(i);
            if (i < n - 1 || underrun) begin
                exp_q.push_back({8'h00, w});
            end else if (mod == 3'd0) begin
                exp_q.push_back({8'h00, w});
                exp_q.push_back(TERM_COL);
            end else begin
                exp_q.push_back(last_col);
            end
        end
        if (underrun) exp_q.push_back(ERR_COL);
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1;
            pkt_data  = base + 64'(i);
            pkt_sop   = (i == 0) || (mid_sop && i == 1);
            pkt_eop   = (i == n - 1) && !underrun;
            pkt_mod   = mod;
            wait_ready(ok);
            if (!ok) break;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        pkt_valid = 1'b1;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        pkt_mod   = 3'd0;
        pkt_data  = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", 72'(xgmii_txd), 72'(64'h0707070707070707));
        check("reset_txc", 72'(xgmii_txc), 72'(8'hFF));
        check("reset_ready", 72'(pkt_ready), 72'(0));
        check("reset_underrun", 72'(underrun_err), 72'(0));
        check("reset_cnt", 72'(tx_frame_cnt), 72'(0));
        pkt_valid = 1'b0;

        // 3-word frame, start at earliest cycle after release
        @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
        send_frame(3, 64'h1111222233334440, 3'd0, 72'h0, 0, 0);
        check("first_start_latency", 72'(last_start_cyc), 72'(rel_cyc + 3));
        wait_idle();
        check("cnt_after_frame1", 72'(tx_frame_cnt), 72'(1));

        // non-SOP word in IDLE is dropped with a one-cycle ready pulse
        pkt_valid = 1'b1;
        pkt_sop   = 1'b0;
        pkt_data  = 64'hDEADBEEFDEADBEEF;
        @(negedge clk);
        check("drop_ready", 72'(pkt_ready), 72'(1));
        @(posedge clk);
        #1 pkt_valid = 1'b0;
        @(negedge clk);
        check("drop_ready_low", 72'(pkt_ready), 72'(0));
        wait_idle();

        // mod = 3 termination
        send_frame(2, 64'h8877665544332210, 3'd3, {8'hF8, 64'h07070707FD332211}, 0, 0);
        wait_idle();
        check("cnt_after_mod3", 72'(tx_frame_cnt), 72'(2));

        // back-to-back frames; second carries a stray SOP mid-frame
        send_frame(2, 64'hAABBCCDDEEFF1121, 3'd7, {8'h80, 64'hFDBBCCDDEEFF1122}, 0, 0);
        send_frame(3, 64'h0102030405060706, 3'd1, {8'hFE, 64'h070707070707FD08}, 1, 0);
        wait_idle();
        check("cnt_after_b2b", 72'(tx_frame_cnt), 72'(4));

        // underrun after 2 data words
        send_frame(2, 64'h5A5A5A5A00000000, 3'd0, 72'h0, 0, 1);
        wait_idle();
        check("cnt_after_underrun", 72'(tx_frame_cnt), 72'(4));

        // asynchronous reset during DATA
        exp_q.push_back(PRE_COL);
        exp_q.push_back({8'h00, 64'hC0FFEE0000000001});
        exp_q.push_back({8'h00, 64'hC0FFEE0000000002});
        pkt_valid = 1'b1;
        pkt_sop   = 1'b1;
        pkt_data  = 64'hC0FFEE0000000001;
        wait_ready(ok);
        @(posedge clk);
        #1;
        pkt_sop  = 1'b0;
        pkt_data = 64'hC0FFEE0000000002;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_txd", 72'(xgmii_txd), 72'(64'h0707070707070707));
        check("async_rst_txc", 72'(xgmii_txc), 72'(8'hFF));
        check("async_rst_ready", 72'(pkt_ready), 72'(0));
        check("async_rst_cnt", 72'(tx_frame_cnt), 72'(0));
        pkt_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
        send_frame(1, 64'h0BADF00D12345678, 3'd0, 72'h0, 0, 0);
        check("restart_latency", 72'(last_start_cyc), 72'(rel_cyc + 3));
        wait_idle();
        check("cnt_after_restart", 72'(tx_frame_cnt), 72'(1));

        // counter wrap
        force dut.frame_cnt = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.frame_cnt;
        @(posedge clk);
        #1;
        send_frame(1, 64'h7766554433221100, 3'd0, 72'h0, 0, 0);
        wait_idle();
        check("cnt_wrap", 72'(tx_frame_cnt), 72'(0));

        wait_idle();
        check("queue_drained", 72'(exp_q.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
